// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 stream encryptor: FSM states, S-box size
// and key-byte selection.
package rc4_pkg;

  localparam int unsigned S_SIZE    = 256;
  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned KEY_BITS  = 8 * KEY_BYTES;
  localparam int unsigned CNT_W     = 9;

  typedef enum logic [4:0] {
    IDLE,
    FILL,
    K_RD_SI,
    K_WAIT_SI,
    K_RD_SJ,
    K_WAIT_SJ,
    K_WR_SI,
    K_WR_SJ,
    P_WAIT_PT,
    P_RD_SI,
    P_WAIT_SI,
    P_RD_SJ,
    P_WAIT_SJ,
    P_WR_SI,
    P_WR_SJ,
    P_RD_K,
    P_WAIT_K,
    P_XOR,
    P_OUT
  } state_e;

  // Key byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] keybyte(input logic [KEY_BITS-1:0] key,
                                         input logic [1:0]          idx);
    logic [7:0] kb;
    kb = 8'h00;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (idx == 2'(k)) kb = key[KEY_BITS-1-8*k -: 8];
    end
    return kb;
  endfunction

endpackage

// File: rtl/rc4_stream_encryptor.sv
// RC4 encryptor: fills and key-schedules an external 256x8 S memory, then runs the
// PRGA and XORs each accepted plaintext byte with the keystream.
module rc4_stream_encryptor
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_LENGTH = 3,
  parameter int unsigned MSG_LENGTH = 32
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] secret_key,
  input  logic                pt_valid,
  input  logic [7:0]          pt_data,
  output logic                pt_ready,
  output logic                ct_valid,
  output logic [7:0]          ct_data,
  input  logic                ct_ready,
  output logic                busy,
  output logic                done,
  output logic [7:0]          s_address,
  output logic [7:0]          s_data,
  output logic                s_wren,
  input  logic [7:0]          s_q
);

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [7:0]          i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, pt_q, pt_d;
  logic [1:0]          kidx_q, kidx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pt_ready_q, pt_ready_d, ct_valid_q, ct_valid_d;
  logic                busy_q, busy_d, done_q, done_d, s_wren_q, s_wren_d;
  logic [7:0]          ct_data_q, ct_data_d, s_address_q, s_address_d, s_data_q, s_data_d;
  logic [7:0]          j_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      key_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      pt_q        <= '0;
      kidx_q      <= '0;
      cnt_q       <= '0;
      pt_ready_q  <= 1'b0;
      ct_valid_q  <= 1'b0;
      ct_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s_address_q <= '0;
      s_data_q    <= '0;
      s_wren_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pt_q        <= pt_d;
      kidx_q      <= kidx_d;
      cnt_q       <= cnt_d;
      pt_ready_q  <= pt_ready_d;
      ct_valid_q  <= ct_valid_d;
      ct_data_q   <= ct_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s_address_q <= s_address_d;
      s_data_q    <= s_data_d;
      s_wren_q    <= s_wren_d;
    end
  end

  // Memory reads land one cycle after the registered address, hence each WAIT state.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pt_d        = pt_q;
    kidx_d      = kidx_q;
    cnt_d       = cnt_q;
    pt_ready_d  = 1'b0;
    ct_valid_d  = ct_valid_q;
    ct_data_d   = ct_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    s_address_d = s_address_q;
    s_data_d    = s_data_q;
    s_wren_d    = 1'b0;
    j_nxt       = j_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = secret_key;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        s_address_d = cnt_q[7:0];
        s_data_d    = cnt_q[7:0];
        s_wren_d    = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(S_SIZE - 1)) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          cnt_d   = '0;
          state_d = K_RD_SI;
        end
      end
      K_RD_SI: begin
        s_address_d = i_q;
        state_d     = K_WAIT_SI;
      end
      K_WAIT_SI: state_d = K_RD_SJ;
      K_RD_SJ: begin
        j_nxt       = j_q + s_q + keybyte(key_q, kidx_q);
        si_d        = s_q;
        j_d         = j_nxt;
        s_address_d = j_nxt;
        state_d     = K_WAIT_SJ;
      end
      K_WAIT_SJ: state_d = K_WR_SI;
      K_WR_SI: begin
        sj_d        = s_q;
        s_address_d = i_q;
        s_data_d    = s_q;
        s_wren_d    = 1'b1;
        state_d     = K_WR_SJ;
      end
      K_WR_SJ: begin
        s_address_d = j_q;
        s_data_d    = si_q;
        s_wren_d    = 1'b1;
        i_d         = i_q + 8'd1;
        kidx_d      = (kidx_q == 2'(KEY_LENGTH - 1)) ? 2'd0 : kidx_q + 2'd1;
        cnt_d       = cnt_q + 1'b1;
        state_d     = K_RD_SI;
        if (cnt_q == CNT_W'(S_SIZE - 1)) begin
          i_d        = '0;
          j_d        = '0;
          cnt_d      = '0;
          pt_ready_d = 1'b1;
          state_d    = P_WAIT_PT;
        end
      end
      P_WAIT_PT: begin
        pt_ready_d = 1'b1;
        if (pt_valid && pt_ready_q) begin
          pt_d       = pt_data;
          pt_ready_d = 1'b0;
          state_d    = P_RD_SI;
        end
      end
      P_RD_SI: begin
        i_d         = i_q + 8'd1;
        s_address_d = i_q + 8'd1;
        state_d     = P_WAIT_SI;
      end
      P_WAIT_SI: state_d = P_RD_SJ;
      P_RD_SJ: begin
        j_nxt       = j_q + s_q;
        si_d        = s_q;
        j_d         = j_nxt;
        s_address_d = j_nxt;
        state_d     = P_WAIT_SJ;
      end
      P_WAIT_SJ: state_d = P_WR_SI;
      P_WR_SI: begin
        sj_d        = s_q;
        s_address_d = i_q;
        s_data_d    = s_q;
        s_wren_d    = 1'b1;
        state_d     = P_WR_SJ;
      end
      P_WR_SJ: begin
        s_address_d = j_q;
        s_data_d    = si_q;
        s_wren_d    = 1'b1;
        state_d     = P_RD_K;
      end
      P_RD_K: begin
        s_address_d = si_q + sj_q;
        state_d     = P_WAIT_K;
      end
      P_WAIT_K: state_d = P_XOR;
      P_XOR: begin
        ct_data_d  = s_q ^ pt_q;
        ct_valid_d = 1'b1;
        state_d    = P_OUT;
      end
      P_OUT: begin
        if (ct_ready) begin
          ct_valid_d = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MSG_LENGTH - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pt_ready_d = 1'b1;
            state_d    = P_WAIT_PT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pt_ready  = pt_ready_q;
  assign ct_valid  = ct_valid_q;
  assign ct_data   = ct_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign s_address = s_address_q;
  assign s_data    = s_data_q;
  assign s_wren    = s_wren_q;

endmodule

// File: tb/tb_rc4_stream_encryptor.sv
// Directed bench for rc4_stream_encryptor with a behavioural S memory (read data
// one cycle after the registered address) and known RC4 "Key"/"Plaintext" vectors.
module tb_rc4_stream_encryptor;

  logic        clk = 1'b0;
  logic        reset, start, pt_valid, ct_ready;
  logic [23:0] secret_key;
  logic [7:0]  pt_data;
  logic        pt_ready, ct_valid, busy, done, s_wren;
  logic [7:0]  ct_data, s_address, s_data, s_q;

  logic [7:0]  mem [256];
  logic [7:0]  pt_v [9];
  logic [7:0]  ct_v [9];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  rc4_stream_encryptor #(.KEY_LENGTH(3), .MSG_LENGTH(9)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .secret_key(secret_key),
    .pt_valid  (pt_valid),
    .pt_data   (pt_data),
    .pt_ready  (pt_ready),
    .ct_valid  (ct_valid),
    .ct_data   (ct_data),
    .ct_ready  (ct_ready),
    .busy      (busy),
    .done      (done),
    .s_address (s_address),
    .s_data    (s_data),
    .s_wren    (s_wren),
    .s_q       (s_q)
  );

  // Single-port S memory: registered read data, write on s_wren.
  always @(posedge clk) begin
    s_q <= mem[s_address];
    if (s_wren) mem[s_address] <= s_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 32'({busy, pt_ready, ct_valid, done, s_wren, s_address, s_data, ct_data}), 32'd0);
  endtask

  task automatic pulse_start(input logic [23:0] key);
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    secret_key = 24'h0;
  endtask

  // One full message; rt swaps plaintext/ciphertext tables for the round trip.
  task automatic run_msg(input logic [23:0] key, input bit rt, input int stall_b,
                         input bit t_chk, input bit hit_busy);
    int         t, bad;
    logic [7:0] src, expv;
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    ct_ready   = 1'b1;
    if (t_chk) begin
      pt_valid = 1'b1;
      pt_data  = rt ? ct_v[0] : pt_v[0];
    end
    @(negedge clk);
    start      = 1'b0;
    secret_key = 24'h0;
    check("busy after start", 32'(busy), 32'd1);
    if (hit_busy) begin
      repeat (10) @(negedge clk);
      secret_key = 24'hFFFFFF;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      secret_key = 24'h0;
      check("busy through ignored start", 32'(busy), 32'd1);
    end
    if (t_chk) begin
      bad = 0;
      for (int m = 0; m < 1792; m++) begin
        if (pt_ready) bad++;
        @(negedge clk);
      end
      check("pt_ready before cycle 1793", 32'(bad), 32'd0);
      check("pt_ready at cycle 1793", 32'(pt_ready), 32'd1);
      @(negedge clk);
      pt_valid = 1'b0;
      check("pt_ready drop after accept", 32'(pt_ready), 32'd0);
      repeat (8) @(negedge clk);
      check("ct_valid low at edge 8", 32'(ct_valid), 32'd0);
      @(negedge clk);
      check("ct_valid high at edge 9", 32'(ct_valid), 32'd1);
    end
    for (int b = 0; b < 9; b++) begin
      src      = rt ? ct_v[b] : pt_v[b];
      expv     = rt ? pt_v[b] : ct_v[b];
      ct_ready = (b == stall_b) ? 1'b0 : 1'b1;
      if (!(t_chk && b == 0)) begin
        pt_valid = 1'b1;
        pt_data  = src;
        t = 0;
        while (!pt_ready && t < 3000) begin
          @(negedge clk);
          t++;
        end
        if (t >= 3000) check("pt_ready timeout", 32'(t), 32'd0);
        @(negedge clk);
        pt_valid = 1'b0;
      end
      t = 0;
      while (!ct_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("ct_valid timeout", 32'(t), 32'd0);
      check($sformatf("ct byte %0d", b), 32'(ct_data), 32'(expv));
      if (b == stall_b) begin
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (!ct_valid || ct_data !== expv || pt_ready || s_wren) bad++;
        end
        check("stall holds ct, no pt_ready/s_wren", 32'(bad), 32'd0);
        ct_ready = 1'b1;
      end
      @(negedge clk);
      check($sformatf("ct_valid drop byte %0d", b), 32'(ct_valid), 32'd0);
      if (b == 8) begin
        check("done pulse", 32'({done, busy}), 32'b10);
        @(negedge clk);
        check("done single cycle", 32'(done), 32'd0);
      end else begin
        check($sformatf("no early done byte %0d", b), 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    pt_v = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct_v = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'h0;
    pt_valid   = 1'b0;
    pt_data    = 8'h00;
    ct_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset outputs");
    reset = 1'b0;

    // Known-answer with first-byte timing and a 20-cycle stall on byte 1 (F3).
    run_msg(24'h4B6579, 1'b0, 1, 1'b1, 1'b0);
    // Round trip: ciphertext back in yields plaintext.
    run_msg(24'h4B6579, 1'b1, -1, 1'b0, 1'b0);
    // Start with a different key while busy must be ignored.
    run_msg(24'h4B6579, 1'b0, -1, 1'b0, 1'b1);

    // Reset in the middle of the KSA, then a clean rerun.
    pulse_start(24'h4B6579);
    repeat (256 + 600) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("outputs after mid-KSA reset");
    reset = 1'b0;
    run_msg(24'h4B6579, 1'b0, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
